// File: rtl/ifu_pkg.sv
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and default sizes for the IFU refill sequencer.
//               Provides the miss-controller state encoding and the default
//               geometry constants used by ifu_miss_ctrl and ifu_miss_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

  // Refill sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } t_miss_state;

  localparam int IFU_TAG_WIDTH        = 27;
  localparam int IFU_LINE_WIDTH       = 128;
  localparam int IFU_OFFSET_WIDTH     = 5;
  localparam int IFU_MISS_QUEUE_DEPTH = 4;
  localparam int IFU_TIMEOUT_CYCLES   = 64;
  localparam int IFU_MAX_RETRY        = 3;

endpackage

`default_nettype wire

// File: rtl/ifu_miss_queue.sv
// ============================================================================
// Module      : ifu_miss_queue
// Description : Circular miss FIFO with a CAM-style tag search.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_tag  : enqueue a tag (caller guarantees space after flush)
//   pop             : retire the head entry
//   flush_all       : discard every entry
//   flush_keep_head : discard every entry except the head
//   match_tag       : tag to search for
//   match_any       : match_tag equals an entry that survives this cycle's flush
//   head_tag        : tag of the oldest entry
//   full, empty     : occupancy flags (current registered contents)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_miss_queue
  import ifu_pkg::*;
#(
  parameter int TAG_WIDTH   = IFU_TAG_WIDTH,
  parameter int QUEUE_DEPTH = IFU_MISS_QUEUE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [TAG_WIDTH-1:0] push_tag,
  input  logic                 pop,
  input  logic                 flush_all,
  input  logic                 flush_keep_head,
  input  logic [TAG_WIDTH-1:0] match_tag,
  output logic                 match_any,
  output logic [TAG_WIDTH-1:0] head_tag,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_WIDTH-1:0]   tag_q [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]   tag_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] valid_q, valid_d;
  logic [QUEUE_DEPTH-1:0] head_oh, surv, hit;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;

  assign head_tag  = tag_q[head_q];
  assign full      = (count_q == CW'(QUEUE_DEPTH));
  assign empty     = (count_q == '0);
  assign match_any = |hit;

  // Dedup only sees entries that survive a same-cycle flush.
  always_comb begin
    head_oh         = '0;
    head_oh[head_q] = 1'b1;
    if (flush_all)            surv = '0;
    else if (flush_keep_head) surv = valid_q & head_oh;
    else                      surv = valid_q;
    hit = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      hit[i] = surv[i] && (tag_q[i] == match_tag);
    end
  end

  // Order of effects: flush, then pop, then push.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_all) begin
      valid_d = '0;
      count_d = '0;
      tail_d  = head_q;
    end else if (flush_keep_head) begin
      valid_d = valid_q & head_oh;
      count_d = empty ? '0 : CW'(1);
      tail_d  = empty ? head_q : head_q + PW'(1);
    end
    if (pop && (count_d != '0)) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
      count_d         = count_d - CW'(1);
    end
    if (push) begin
      valid_d[tail_d] = 1'b1;
      tag_d[tail_d]   = push_tag;
      tail_d          = tail_d + PW'(1);
      count_d         = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      tag_q   <= tag_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu_miss_ctrl.sv
// ============================================================================
// Module      : ifu_miss_ctrl
// Description : Refill sequencer between the instruction cache and memory.
//   Clock, Rst                       : clock, asynchronous active-low reset
//   miss_tagIn/ValidIn               : miss tags from the cache (deduplicated)
//   flushIn                          : fetch redirect, drops unissued misses
//   fill_tagOut/lineOut/validOut     : one-cycle fill back to the cache
//   mem_reqAddrOut/ValidOut/ReadyIn  : line read request handshake
//   mem_rspLineIn/ValidIn            : read data return
//   busyOut, queueFullOut            : status
//   missDropOut                      : pulse, miss lost to a full queue
//   errorOut                         : sticky, a request exhausted its retries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_miss_ctrl
  import ifu_pkg::*;
#(
  parameter int TAG_WIDTH      = IFU_TAG_WIDTH,
  parameter int LINE_WIDTH     = IFU_LINE_WIDTH,
  parameter int OFFSET_WIDTH   = IFU_OFFSET_WIDTH,
  parameter int QUEUE_DEPTH    = IFU_MISS_QUEUE_DEPTH,
  parameter int TIMEOUT_CYCLES = IFU_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = IFU_MAX_RETRY
) (
  input  logic                              Clock,
  input  logic                              Rst,
  input  logic [TAG_WIDTH-1:0]              miss_tagIn,
  input  logic                              miss_tagValidIn,
  input  logic                              flushIn,
  output logic [TAG_WIDTH-1:0]              fill_tagOut,
  output logic [LINE_WIDTH-1:0]             fill_lineOut,
  output logic                              fill_validOut,
  output logic [TAG_WIDTH+OFFSET_WIDTH-1:0] mem_reqAddrOut,
  output logic                              mem_reqValidOut,
  input  logic                              mem_reqReadyIn,
  input  logic [LINE_WIDTH-1:0]             mem_rspLineIn,
  input  logic                              mem_rspValidIn,
  output logic                              busyOut,
  output logic                              queueFullOut,
  output logic                              missDropOut,
  output logic                              errorOut
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  t_miss_state           state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic                  error_q, error_d;
  logic                  req_valid_q, req_valid_d;
  logic                  fill_valid_q, fill_valid_d;
  logic                  drop_q, drop_d;
  logic [TAG_WIDTH-1:0]  fill_tag_q, fill_tag_d;
  logic [LINE_WIDTH-1:0] fill_line_q, fill_line_d;

  logic                  q_push, q_pop, q_flush_all, q_flush_keep;
  logic                  q_match, q_full, q_empty;
  logic [TAG_WIDTH-1:0]  q_head;

  ifu_miss_queue #(
    .TAG_WIDTH   (TAG_WIDTH),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk             (Clock),
    .rst_n           (Rst),
    .push            (q_push),
    .push_tag        (miss_tagIn),
    .pop             (q_pop),
    .flush_all       (q_flush_all),
    .flush_keep_head (q_flush_keep),
    .match_tag       (miss_tagIn),
    .match_any       (q_match),
    .head_tag        (q_head),
    .full            (q_full),
    .empty           (q_empty)
  );

  always_comb begin
    q_flush_all  = flushIn && (state_q == IDLE);
    q_flush_keep = flushIn && (state_q != IDLE);
    // Fullness is judged before any same-cycle pop; a flush always frees room.
    q_push       = miss_tagValidIn && !q_match && !(q_full && !flushIn);
    drop_d       = miss_tagValidIn && !q_match && q_full && !flushIn;

    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    error_d     = error_q;
    fill_tag_d  = fill_tag_q;
    fill_line_d = fill_line_q;
    q_pop       = 1'b0;

    case (state_q)
      IDLE: begin
        // Entries being flushed this cycle must not be requested.
        if (!q_empty && !flushIn) state_d = REQ;
      end
      REQ: begin
        if (mem_reqReadyIn) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (mem_rspValidIn) begin
          state_d     = FILL;
          fill_tag_d  = q_head;
          fill_line_d = mem_rspLineIn;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timer_d = '0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = REQ;
          end else begin
            error_d = 1'b1;
            q_pop   = 1'b1;
            retry_d = '0;
            state_d = IDLE;
          end
        end
      end
      FILL: begin
        q_pop   = 1'b1;
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_valid_d  = (state_d == REQ);
    fill_valid_d = (state_d == FILL);
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      error_q      <= 1'b0;
      req_valid_q  <= 1'b0;
      fill_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      fill_tag_q   <= '0;
      fill_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      error_q      <= error_d;
      req_valid_q  <= req_valid_d;
      fill_valid_q <= fill_valid_d;
      drop_q       <= drop_d;
      fill_tag_q   <= fill_tag_d;
      fill_line_q  <= fill_line_d;
    end
  end

  // The head cannot change while in REQ, so the address holds until accepted.
  assign mem_reqAddrOut  = req_valid_q ? {q_head, {OFFSET_WIDTH{1'b0}}} : '0;
  assign mem_reqValidOut = req_valid_q;
  assign fill_validOut   = fill_valid_q;
  assign fill_tagOut     = fill_tag_q;
  assign fill_lineOut    = fill_line_q;
  assign missDropOut     = drop_q;
  assign errorOut        = error_q;
  assign queueFullOut    = q_full;
  assign busyOut         = !q_empty || (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ifu_miss_ctrl.sv
// ============================================================================
// Module      : tb_ifu_miss_ctrl
// Description : Directed self-checking bench for ifu_miss_ctrl
//               (TIMEOUT_CYCLES=8, MAX_RETRY=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_miss_ctrl;

  logic          Clock = 1'b0;
  logic          Rst   = 1'b1;
  logic [26:0]   miss_tagIn = '0;
  logic          miss_tagValidIn = 1'b0;
  logic          flushIn = 1'b0;
  logic [26:0]   fill_tagOut;
  logic [127:0]  fill_lineOut;
  logic          fill_validOut;
  logic [31:0]   mem_reqAddrOut;
  logic          mem_reqValidOut;
  logic          mem_reqReadyIn = 1'b0;
  logic [127:0]  mem_rspLineIn = '0;
  logic          mem_rspValidIn = 1'b0;
  logic          busyOut;
  logic          queueFullOut;
  logic          missDropOut;
  logic          errorOut;

  int n_total = 0;
  int n_bad   = 0;

  logic [26:0] t2 [6] = '{27'h1, 27'h1, 27'h2, 27'h3, 27'h4, 27'h5};
  logic [26:0] t4 [3] = '{27'h1, 27'h2, 27'h3};
  int hs [4];

  localparam logic [127:0] L_DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  ifu_miss_ctrl #(
    .TIMEOUT_CYCLES (8),
    .MAX_RETRY      (2)
  ) dut (
    .Clock           (Clock),
    .Rst             (Rst),
    .miss_tagIn      (miss_tagIn),
    .miss_tagValidIn (miss_tagValidIn),
    .flushIn         (flushIn),
    .fill_tagOut     (fill_tagOut),
    .fill_lineOut    (fill_lineOut),
    .fill_validOut   (fill_validOut),
    .mem_reqAddrOut  (mem_reqAddrOut),
    .mem_reqValidOut (mem_reqValidOut),
    .mem_reqReadyIn  (mem_reqReadyIn),
    .mem_rspLineIn   (mem_rspLineIn),
    .mem_rspValidIn  (mem_rspValidIn),
    .busyOut         (busyOut),
    .queueFullOut    (queueFullOut),
    .missDropOut     (missDropOut),
    .errorOut        (errorOut)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Wait for a request, accept it, answer on the first WAIT cycle, check the fill.
  task automatic serve(input logic [26:0] t, input logic [127:0] line);
    int n = 0;
    mem_reqReadyIn = 1'b1;
    while (!mem_reqValidOut && n < 30) begin
      step(1);
      n++;
    end
    chk("serve_req", 128'(mem_reqValidOut), 128'd1);
    chk("serve_addr", 128'(mem_reqAddrOut), 128'({t, 5'b0}));
    step(1);
    mem_reqReadyIn = 1'b0;
    chk("serve_wait", 128'(mem_reqValidOut), 128'd0);
    mem_rspValidIn = 1'b1;
    mem_rspLineIn  = line;
    step(1);
    mem_rspValidIn = 1'b0;
    chk("serve_fill_v", 128'(fill_validOut), 128'd1);
    chk("serve_fill_tag", 128'(fill_tagOut), 128'(t));
    chk("serve_fill_line", fill_lineOut, line);
    step(1);
    chk("serve_fill_pulse", 128'(fill_validOut), 128'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fillv"}, 128'(fill_validOut), 128'd0);
    chk({tag, "_reqv"}, 128'(mem_reqValidOut), 128'd0);
    chk({tag, "_addr"}, 128'(mem_reqAddrOut), 128'd0);
    chk({tag, "_busy"}, 128'(busyOut), 128'd0);
    chk({tag, "_full"}, 128'(queueFullOut), 128'd0);
    chk({tag, "_drop"}, 128'(missDropOut), 128'd0);
    chk({tag, "_err"}, 128'(errorOut), 128'd0);
    chk({tag, "_ftag"}, 128'(fill_tagOut), 128'd0);
    chk({tag, "_fline"}, fill_lineOut, 128'd0);
  endtask

  initial begin
    int nhs, nfill, errc;

    // Reset
    #2 Rst = 1'b0;
    step(2);
    Rst = 1'b1;
    chk_all_zero("rst");

    // Single miss, response three cycles after accept
    miss_tagIn = 27'h1; miss_tagValidIn = 1'b1; mem_reqReadyIn = 1'b1;
    step(1); miss_tagValidIn = 1'b0;
    chk("t1_c1_busy", 128'(busyOut), 128'd1);
    chk("t1_c1_req", 128'(mem_reqValidOut), 128'd0);
    step(1);
    chk("t1_c2_req", 128'(mem_reqValidOut), 128'd1);
    chk("t1_c2_addr", 128'(mem_reqAddrOut), 128'h20);
    step(1);
    chk("t1_c3_req", 128'(mem_reqValidOut), 128'd0);
    mem_reqReadyIn = 1'b0;
    step(2);
    mem_rspValidIn = 1'b1; mem_rspLineIn = L_DEAD;
    chk("t1_c5_fill", 128'(fill_validOut), 128'd0);
    step(1); mem_rspValidIn = 1'b0;
    chk("t1_fill_v", 128'(fill_validOut), 128'd1);
    chk("t1_fill_tag", 128'(fill_tagOut), 128'h1);
    chk("t1_fill_line", fill_lineOut, L_DEAD);
    step(1);
    chk("t1_fill_pulse", 128'(fill_validOut), 128'd0);
    chk("t1_idle_busy", 128'(busyOut), 128'd0);

    // Dedup and full with memory stalled
    mem_reqReadyIn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      miss_tagIn = t2[i]; miss_tagValidIn = 1'b1;
      step(1);
      chk("t2_drop", 128'(missDropOut), 128'(i == 5));
      chk("t2_req_hold", 128'(mem_reqValidOut), 128'(i >= 1));
    end
    miss_tagValidIn = 1'b0;
    chk("t2_full", 128'(queueFullOut), 128'd1);
    chk("t2_head_addr", 128'(mem_reqAddrOut), 128'h20);
    step(1);
    chk("t2_drop_pulse", 128'(missDropOut), 128'd0);
    serve(27'h1, 128'h1111);
    serve(27'h2, 128'h2222);
    serve(27'h3, 128'h3333);
    serve(27'h4, 128'h4444);
    chk("t2_end_busy", 128'(busyOut), 128'd0);

    // Timeout and retry, no response ever
    nhs = 0; nfill = 0; errc = -1;
    miss_tagIn = 27'h7; miss_tagValidIn = 1'b1; mem_reqReadyIn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (mem_reqValidOut && mem_reqReadyIn) begin
        if (nhs < 4) hs[nhs] = c;
        nhs++;
      end
      if (fill_validOut) nfill++;
      if (errorOut && errc < 0) errc = c;
      step(1);
      miss_tagValidIn = 1'b0;
    end
    mem_reqReadyIn = 1'b0;
    chk("t3_handshakes", 128'(nhs), 128'd3);
    chk("t3_hs0", 128'(hs[0]), 128'd2);
    chk("t3_hs1", 128'(hs[1]), 128'd11);
    chk("t3_hs2", 128'(hs[2]), 128'd20);
    chk("t3_err_cycle", 128'(errc), 128'd29);
    chk("t3_no_fill", 128'(nfill), 128'd0);
    chk("t3_busy", 128'(busyOut), 128'd0);
    chk("t3_err_sticky", 128'(errorOut), 128'd1);

    // Flush while head in WAIT, with a same-cycle miss
    mem_reqReadyIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      miss_tagIn = t4[i]; miss_tagValidIn = 1'b1;
      step(1);
    end
    miss_tagValidIn = 1'b0;
    chk("t4_in_wait", 128'(mem_reqValidOut), 128'd0);
    step(1);
    flushIn = 1'b1; miss_tagIn = 27'h9; miss_tagValidIn = 1'b1;
    step(1);
    flushIn = 1'b0; miss_tagValidIn = 1'b0;
    mem_rspValidIn = 1'b1; mem_rspLineIn = 128'hAAAA;
    step(1);
    mem_rspValidIn = 1'b0;
    chk("t4_fill_v", 128'(fill_validOut), 128'd1);
    chk("t4_fill_tag", 128'(fill_tagOut), 128'h1);
    serve(27'h9, 128'h9999);
    chk("t4_end_busy", 128'(busyOut), 128'd0);

    // Stray responses in IDLE and in REQ
    mem_reqReadyIn = 1'b0;
    mem_rspValidIn = 1'b1; mem_rspLineIn = 128'h5555;
    step(1);
    mem_rspValidIn = 1'b0;
    chk("t5_idle_fill", 128'(fill_validOut), 128'd0);
    chk("t5_idle_busy", 128'(busyOut), 128'd0);
    miss_tagIn = 27'h5; miss_tagValidIn = 1'b1;
    step(1); miss_tagValidIn = 1'b0;
    step(1);
    chk("t5_req", 128'(mem_reqValidOut), 128'd1);
    mem_rspValidIn = 1'b1;
    step(1);
    mem_rspValidIn = 1'b0;
    chk("t5_req_fill", 128'(fill_validOut), 128'd0);
    chk("t5_req_hold", 128'(mem_reqValidOut), 128'd1);
    chk("t5_req_addr", 128'(mem_reqAddrOut), 128'hA0);

    // Reset in WAIT, then a late response
    mem_reqReadyIn = 1'b1;
    step(1);
    mem_reqReadyIn = 1'b0;
    chk("t6_wait", 128'(mem_reqValidOut), 128'd0);
    chk("t6_wait_busy", 128'(busyOut), 128'd1);
    Rst = 1'b0;
    step(1);
    Rst = 1'b1;
    chk_all_zero("t6_rst");
    mem_rspValidIn = 1'b1; mem_rspLineIn = 128'h6666;
    step(1);
    mem_rspValidIn = 1'b0;
    chk("t6_late_fill", 128'(fill_validOut), 128'd0);
    chk("t6_late_busy", 128'(busyOut), 128'd0);
    step(1);
    chk("t6_late_fill2", 128'(fill_validOut), 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifu_miss_ctrl.md
# ifu_miss_ctrl

Refill sequencer between the instruction cache and instruction memory.
- Cache side: accepts miss tags from the IFU cache and filters duplicates.
- Memory side: queues misses in a small CAM-searchable FIFO and issues one outstanding memory read at a time with a valid/ready handshake.
- Return path: delivers each returned line back to the cache as a one-cycle fill pulse.
- Error handling: each request has a timeout; a timed-out request is retried a bounded number of times, then dropped with a sticky error.

## Interface
- TAG_WIDTH, 27, line tag width (address bits above the line offset)
- LINE_WIDTH, 128, instruction line width
- OFFSET_WIDTH, 5, line offset bits; the memory address is {tag, OFFSET_WIDTH'b0}
- QUEUE_DEPTH, 4, miss queue entries (power of two, ≥2)
- TIMEOUT_CYCLES, 64, WAIT cycles allowed before retry
- MAX_RETRY, 3, retries before the entry is dropped

Clock is single; reset is asynchronous, active-low.
- Clock  in  1  sole clock
- Rst  in  1  asynchronous active-low reset
- miss_tagIn  in  TAG_WIDTH  missing line tag from cache
- miss_tagValidIn  in  1  miss_tagIn valid this cycle
- flushIn  in  1  fetch redirect; discard unissued queue entries
- fill_tagOut  out  TAG_WIDTH  tag of returned line
- fill_lineOut  out  LINE_WIDTH  returned line
- fill_validOut  out  1  one-cycle fill strobe to cache
- mem_reqAddrOut  out  TAG_WIDTH+OFFSET_WIDTH  line-aligned read address
- mem_reqValidOut  out  1  read request valid
- mem_reqReadyIn  in  1  memory accepts request
- mem_rspLineIn  in  LINE_WIDTH  read data
- mem_rspValidIn  in  1  read data valid
- busyOut  out  1  queue non-empty or state≠IDLE
- queueFullOut  out  1  all QUEUE_DEPTH entries valid
- missDropOut  out  1  pulse: non-duplicate miss lost because queue full
- errorOut  out  1  sticky: an entry exhausted its retries

## Operation
FSM states are IDLE, REQ, WAIT and FILL.
- IDLE: queue non-empty → REQ; otherwise stay.
- REQ: mem_reqValidOut=1 and mem_reqAddrOut={head tag, 0}.
  - The address is held stable until handshake.
  - mem_reqValidOut && mem_reqReadyIn → WAIT; timer cleared.
- WAIT: the timer increments each cycle.
  - mem_rspValidIn → FILL; the line is captured.
  - Timer==TIMEOUT_CYCLES-1 with no response: if retry<MAX_RETRY, retry++ and → REQ.
  - Otherwise errorOut set, head popped, retry cleared, → IDLE.
- FILL: fill_validOut=1 with the captured tag and line; head popped; retry cleared; → IDLE.

Queue push rules:
- Push when miss_tagValidIn, the tag matches no valid entry, and the queue is not full.
- A tag matching any valid entry, including the in-flight head, is absorbed silently.
- Full is evaluated before the same-cycle pop, so a push arriving while full is dropped with missDropOut=1, even in FILL.

Flush rules:
- flushIn in IDLE empties the queue.
- flushIn in any other state keeps only the head; the in-flight request completes and fills normally.
- Flush is applied before a same-cycle push: a miss arriving with flushIn is enqueued, with dedup checked only against survivors.

Other rules:
- mem_rspValidIn outside WAIT is ignored; there is no state change and no fill.
- errorOut clears only on reset.

## Timing
- Reset: state IDLE, queue empty, timer=0, retry=0; every output 0.
- Reset mid-transaction discards everything. A later stray response is ignored because the FSM is in IDLE.
- Miss in cycle 0 with an empty idle controller: entry valid in cycle 1, mem_reqValidOut high in cycle 2.
- Response in cycle k: fill_validOut high in cycle k+1 only; next REQ no earlier than k+3.
- Timeout: with no response, the WAIT phase lasts exactly TIMEOUT_CYCLES cycles per attempt.
- fill_validOut, missDropOut: single-cycle pulses.
- mem_reqValidOut: stays high until accepted; never deasserts in REQ.
- Timer width: $clog2(TIMEOUT_CYCLES). Retry width: $clog2(MAX_RETRY+1).
- Queue pointers: $clog2(QUEUE_DEPTH) bits, wrapping naturally. Count: one extra bit.

## Structure
- ifu_pkg:
  - t_miss_state enum (IDLE, REQ, WAIT, FILL)
  - default constants IFU_TAG_WIDTH, IFU_LINE_WIDTH, IFU_OFFSET_WIDTH, IFU_MISS_QUEUE_DEPTH
- Sub-module ifu_miss_queue: circular FIFO.
  - Ports: push, pop, flush_keep_head, head tag, full/empty, and a combinational match-any output for dedup.
- The FSM, timer and retry counter live in ifu_miss_ctrl.

## Test plan
- Single miss: tag 0x0000001, memory ready immediately, response 3 cycles after accept with 0xDEADBEEF…
  - Expect: mem_reqAddrOut=0x00000020 in cycle 2; fill_validOut one cycle with tag 0x0000001 and that line.
- Dedup/full: misses 0x1, 0x1, 0x2, 0x3, 0x4, 0x5 back-to-back, memory stalled (ready=0).
  - Expect: 4 entries, queueFullOut=1, missDropOut pulse only on 0x5.
  - Expect: later fills in order 0x1, 0x2, 0x3, 0x4.
- Timeout/retry: TIMEOUT_CYCLES=8, MAX_RETRY=2, no response.
  - Expect: 3 request handshakes 8 WAIT cycles apart, then errorOut=1, queue empty, no fill.
- Flush: queue holds 0x1 (in WAIT), 0x2, 0x3; flushIn with miss 0x9 in the same cycle.
  - Expect: 0x1 fills, then 0x9 is requested; 0x2 and 0x3 are never requested.
- Stray response: mem_rspValidIn in IDLE and in REQ.
  - Expect: no fill_validOut, state unchanged.
- Reset in WAIT: Rst low for 1 cycle, then a response arrives.
  - Expect: all outputs 0, busyOut=0, response ignored.
